// File: rtl/fma_norm_pipe_if.sv
// Handshake/data bundle for fma_norm_pipe: upstream sum operand and downstream
// pre-normalized result, each with its own valid/ready pair.
interface fma_norm_pipe_if #(
  parameter int PARM_EXP           = 8,
  parameter int PARM_MANT          = 23,
  parameter int PARM_LEADONE_WIDTH = 7,
  parameter int PARM_SIDE          = 16
);
  localparam int MW  = 3*PARM_MANT+5;
  localparam int RSW = MW+2;
  localparam int EW  = PARM_EXP+2;

  logic                          valid;
  logic                          ready;
  logic [MW-1:0]                 mant;
  logic [EW-1:0]                 exp;
  logic                          sign;
  logic [PARM_SIDE-1:0]          side;

  logic                          out_valid;
  logic                          out_ready;
  logic [MW-1:0]                 mant_norm;
  logic [EW-1:0]                 exp_norm;
  logic [EW-1:0]                 exp_norm_mone;
  logic [EW-1:0]                 exp_max_rs;
  logic [RSW-1:0]                rs_mant;
  logic [PARM_LEADONE_WIDTH-1:0] shift_num;
  logic                          allzero;
  logic                          out_sign;
  logic [PARM_SIDE-1:0]          out_side;

  modport master (
    output valid, mant, exp, sign, side, out_ready,
    input  ready, out_valid, mant_norm, exp_norm, exp_norm_mone, exp_max_rs,
           rs_mant, shift_num, allzero, out_sign, out_side
  );

  modport slave (
    input  valid, mant, exp, sign, side, out_ready,
    output ready, out_valid, mant_norm, exp_norm, exp_norm_mone, exp_max_rs,
           rs_mant, shift_num, allzero, out_sign, out_side
  );
endinterface

// File: rtl/fma_norm_pipe.sv
// Two-stage elastic pre-normalization ahead of FMA normalize-and-round.
// Optional FMA_NORM_FLUSH_EN adds a flush input that empties both stages.
module fma_norm_pipe #(
  parameter int PARM_EXP           = 8,
  parameter int PARM_MANT          = 23,
  parameter int PARM_LEADONE_WIDTH = 7,
  parameter int PARM_SIDE          = 16
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef FMA_NORM_FLUSH_EN
  input  logic           flush,
`endif
  fma_norm_pipe_if.slave bus
);
  localparam int MW  = 3*PARM_MANT+5;
  localparam int RSW = MW+2;
  localparam int EW  = PARM_EXP+2;
  localparam int LW  = PARM_LEADONE_WIDTH;
  localparam int CW  = (EW > LW) ? EW : LW;

  logic                 kill;
  logic                 s1_valid, s2_valid;
  logic                 s1_adv, load, ready;
  logic [MW-1:0]        s1_mant;
  logic [EW-1:0]        s1_exp;
  logic                 s1_sign, s1_zero;
  logic [PARM_SIDE-1:0] s1_side;
  logic [LW-1:0]        s1_lz, lz_in;

  logic [CW-1:0]        lz_w, exp_w;
  logic [EW-1:0]        s_amt;
  logic [EW:0]          rs_sh;
  logic [RSW-1:0]       rs_ext, rs_val;

`ifdef FMA_NORM_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign s1_adv    = s1_valid & (~s2_valid | bus.out_ready);
  assign ready     = ~s1_valid | s1_adv;
  assign load      = bus.valid & ready & ~kill;
  assign bus.ready = ready;
  assign bus.out_valid = s2_valid;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    lz_in = LW'(MW);
    for (int unsigned i = 0; i < MW; i++) begin
      if (bus.mant[i]) lz_in = LW'(MW - 1 - i);
    end
  end

  always_comb begin
    lz_w  = CW'(s1_lz);
    exp_w = CW'(s1_exp);
    s_amt = '0;
    if (!s1_exp[EW-1] && !s1_zero) begin
      s_amt = (lz_w < exp_w) ? EW'(s1_lz) : s1_exp;
    end
  end

  // Right-shift distance 1 - exp is always positive when exp is negative.
  always_comb begin
    rs_ext = {s1_mant, 2'b00};
    rs_sh  = (EW+1)'(1) - {s1_exp[EW-1], s1_exp};
    rs_val = rs_ext;
    if (s1_exp[EW-1]) begin
      rs_val = (32'(rs_sh) >= RSW) ? '0 : (rs_ext >> rs_sh);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (kill) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= load | (s1_valid & ~s1_adv);
      s2_valid <= s1_adv | (s2_valid & ~bus.out_ready);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mant <= '0;
      s1_exp  <= '0;
      s1_sign <= 1'b0;
      s1_side <= '0;
      s1_lz   <= '0;
      s1_zero <= 1'b0;
    end else if (load) begin
      s1_mant <= bus.mant;
      s1_exp  <= bus.exp;
      s1_sign <= bus.sign;
      s1_side <= bus.side;
      s1_lz   <= lz_in;
      s1_zero <= (bus.mant == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mant_norm     <= '0;
      bus.exp_norm      <= '0;
      bus.exp_norm_mone <= '0;
      bus.exp_max_rs    <= '0;
      bus.rs_mant       <= '0;
      bus.shift_num     <= '0;
      bus.allzero       <= 1'b0;
      bus.out_sign      <= 1'b0;
      bus.out_side      <= '0;
    end else if (s1_adv && !kill) begin
      bus.mant_norm     <= s1_mant << s_amt;
      bus.exp_norm      <= s1_exp - s_amt;
      bus.exp_norm_mone <= s1_exp - s_amt - EW'(1);
      bus.exp_max_rs    <= s1_exp + EW'(PARM_MANT + 2);
      bus.rs_mant       <= rs_val;
      bus.shift_num     <= s1_lz;
      bus.allzero       <= s1_zero;
      bus.out_sign      <= s1_sign;
      bus.out_side      <= s1_side;
    end
  end
endmodule

// File: tb/tb_fma_norm_pipe.sv
// Randomized and directed bench for fma_norm_pipe against an arithmetic
// reference model, with in-order scoreboarding of delivered results.
module tb_fma_norm_pipe;
  typedef struct packed {
    logic [73:0] mant_norm;
    logic [9:0]  exp_norm;
    logic [9:0]  exp_norm_mone;
    logic [9:0]  exp_max_rs;
    logic [75:0] rs_mant;
    logic [6:0]  shift_num;
    logic        allzero;
    logic        sign;
    logic [15:0] side;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fma_norm_pipe_if #(.PARM_EXP(8), .PARM_MANT(23), .PARM_LEADONE_WIDTH(7), .PARM_SIDE(16)) bus();

`ifdef FMA_NORM_FLUSH_EN
  logic flush = 1'b0;
`endif

  fma_norm_pipe #(.PARM_EXP(8), .PARM_MANT(23), .PARM_LEADONE_WIDTH(7), .PARM_SIDE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef FMA_NORM_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  res_t exp_q[$];
  res_t got_q[$];

  function automatic res_t model(input logic [73:0] m, input logic [9:0] e,
                                 input logic s, input logic [15:0] sd);
    res_t        r;
    int          ei, l, sh;
    logic [75:0] ext;
    ei = int'($signed(e));
    l  = 74;
    for (int b = 0; b < 74; b++) if (m[b]) l = 73 - b;
    if (ei < 0 || m == '0) sh = 0;
    else sh = (l < ei) ? l : ei;
    r.mant_norm     = m << sh;
    r.exp_norm      = 10'(ei - sh);
    r.exp_norm_mone = 10'(ei - sh - 1);
    r.exp_max_rs    = 10'(ei + 23 + 2);
    ext = {m, 2'b00};
    if (ei < 0) r.rs_mant = (1 - ei >= 76) ? 76'd0 : (ext >> (1 - ei));
    else        r.rs_mant = ext;
    r.shift_num = 7'(l);
    r.allzero   = (m == '0);
    r.sign      = s;
    r.side      = sd;
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.mant_norm     = bus.mant_norm;
    r.exp_norm      = bus.exp_norm;
    r.exp_norm_mone = bus.exp_norm_mone;
    r.exp_max_rs    = bus.exp_max_rs;
    r.rs_mant       = bus.rs_mant;
    r.shift_num     = bus.shift_num;
    r.allzero       = bus.allzero;
    r.sign          = bus.out_sign;
    r.side          = bus.out_side;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) got_q.push_back(observed());
  end

  task automatic send(input logic [73:0] m, input logic [9:0] e,
                      input logic s, input logic [15:0] sd);
    int n = 0;
    bus.valid = 1'b1; bus.mant = m; bus.exp = e; bus.sign = s; bus.side = sd;
    do begin @(negedge clk); n++; end while (!bus.ready && n < 300);
    if (!bus.ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout ready=%b required=1", bus.ready);
    end else begin
      exp_q.push_back(model(m, e, s, sd));
    end
    @(posedge clk); #1;
    bus.valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 500) begin @(negedge clk); n++; end
    if (got_q.size() < exp_q.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_drain delivered=%0d required=%0d", tag, got_q.size(), exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [73:0] rand_mant();
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    return 74'(w) >> $urandom_range(0, 74);
  endfunction

  task automatic test_reset();
    bus.valid = 1'b0; bus.mant = '0; bus.exp = '0; bus.sign = 1'b0; bus.side = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b required=0", bus.out_valid); end
    n_cmp++;
    if (observed() !== '0) begin n_bad++; $display("FAIL reset_data got=%h required=0", observed()); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b required=1", bus.ready); end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid got=%b required=0", bus.out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    res_t e, g;
    bus.out_ready = 1'b1;
    send({1'b1, 73'($urandom)}, 10'd10, 1'b1, 16'hA5C3);
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL latency_early got=%b required=0", bus.out_valid); end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL latency_2cyc got=%b required=1", bus.out_valid); end
    wait_drain("latency");
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL latency_data got=%h required=%h", g, e); end
    end
  endtask

  task automatic test_directed();
    logic [73:0] m_tab[10];
    logic [9:0]  e_tab[10];
    res_t        e, g;
    int          k = 0;
    m_tab[0] = 74'd1 << 50; e_tab[0] = 10'd100;
    m_tab[1] = 74'd1 << 50; e_tab[1] = 10'd5;
    m_tab[2] = 74'd1 << 73; e_tab[2] = 10'h3FD;
    m_tab[3] = 74'd1 << 73; e_tab[3] = 10'(-80);
    m_tab[4] = 74'd0;       e_tab[4] = 10'd40;
    m_tab[5] = 74'd1;       e_tab[5] = 10'd0;
    m_tab[6] = 74'h3;       e_tab[6] = 10'h3FF;
    m_tab[7] = 74'd1 << 73; e_tab[7] = 10'(-74);
    m_tab[8] = 74'd1 << 73; e_tab[8] = 10'(-75);
    m_tab[9] = 74'd1;       e_tab[9] = 10'd511;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(m_tab[i], e_tab[i], 1'($urandom), 16'($urandom));
    wait_drain("directed");
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL directed[%0d] got=%h required=%h", k, g, e); end
      k++;
    end
  endtask

  task automatic test_random();
    bit   done = 1'b0;
    res_t e, g;
    int   k = 0;
    logic [9:0] ex;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          case ($urandom_range(0, 3))
            0:       ex = 10'($urandom_range(0, 1023));
            1:       ex = 10'($urandom_range(0, 80));
            2:       ex = 10'(-int'($urandom_range(1, 90)));
            default: ex = 10'($urandom_range(0, 8));
          endcase
          send(rand_mant(), ex, 1'($urandom), 16'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain("random");
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL random[%0d] got=%h required=%h", k, g, e); end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    res_t hold, e, g;
    int   k = 0;
    bus.out_ready = 1'b1;
    fork
      for (int i = 0; i < 4; i++) send(rand_mant(), 10'($urandom_range(0, 90)), 1'($urandom), 16'(i));
      begin
        repeat (2) begin @(posedge clk); #1; end
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_full got=%b required=0", bus.ready); end
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_held got=%b required=1", bus.out_valid); end
        hold = observed();
        repeat (2) begin
          @(negedge clk);
          n_cmp++;
          if (bus.out_valid !== 1'b1 || observed() !== hold) begin
            n_bad++;
            $display("FAIL b2b_stable got=%b/%h required=1/%h", bus.out_valid, observed(), hold);
          end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain("b2b");
    n_cmp++;
    if (got_q.size() !== 4) begin n_bad++; $display("FAIL b2b_count got=%0d required=4", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL b2b_order[%0d] got=%h required=%h", k, g, e); end
      k++;
    end
  endtask

  task automatic test_reset_mid_stall();
    bus.out_ready = 1'b0;
    send(rand_mant(), 10'd20, 1'b0, 16'h1111);
    send(rand_mant(), 10'd30, 1'b1, 16'h2222);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid got=%b required=1", bus.out_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL async_reset_valid got=%b required=0", bus.out_valid); end
    n_cmp++;
    if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL async_reset_ready got=%b required=1", bus.ready); end
    n_cmp++;
    if (observed() !== '0) begin n_bad++; $display("FAIL async_reset_data got=%h required=0", observed()); end
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || got_q.size() != 0) begin
      n_bad++;
      $display("FAIL post_reset_empty got=%b/%0d required=0/0", bus.out_valid, got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached required=finish");
    $fatal(1, "timeout");
  end
endmodule
